ccg_response_misr: RTL and testbench
====================================

# ccg_response_misr

Downstream response compactor for the CCGRCG219 combinational benchmark. Accepts the 19-bit output vector f1..f19 once per handshake beat over a run of NUM_VECTORS beats and folds every beat into a multiple-input signature register (MISR). It also keeps per-run statistics: ones-counts for the two distinct output functions, and a count of beats where duplicated output copies disagree. The signature and counters are compared against golden values to validate a netlist variant (e.g. a RESYN2 result) against its source.

## Interface
Parameters:
- SIG_W, 32, signature width; must be ≥ 19.
- POLY, 32'h04C11DB7, MISR feedback polynomial; the low SIG_W bits are used.
- SEED, 0, signature value loaded on reset and on start.
- NUM_VECTORS, 1024, beats per run; must be ≥ 1 and < 2^CNT_W.
- CNT_W, 16, width of all counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high; one clock.
- start  in  1  single-cycle pulse that clears state and begins a run.
- in_valid  in  1  f_vec holds a valid beat.
- in_ready  out  1  block accepts a beat this cycle.
- f_vec  in  19  bit i-1 = f_i.
- sig  out  SIG_W  running/final signature.
- ones_f1  out  CNT_W  accepted beats with f_vec[0]=1.
- ones_f8  out  CNT_W  accepted beats with f_vec[7]=1.
- mismatch_cnt  out  CNT_W  accepted beats with a non-uniform copy group.
- vec_cnt  out  CNT_W  beats accepted this run.
- busy  out  1  state==RUN.
- done  out  1  state==DONE.

## Operation
- Copy groups:
  - Group A (copies of f1) = f_vec bits {0..6, 11, 13, 14}.
  - Group B (copies of f8) = bits {7..10, 12, 15..18}.
  - A beat is a mismatch if either group is not all-0 or all-1.
- States: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --final accept (vec_cnt reaches NUM_VECTORS)--> DONE.
  - RUN --start--> RUN (restart).
  - DONE --start--> RUN.
- On start, in any state:
  - sig←SEED; all counters←0.
  - state←RUN.
- in_ready = (state==RUN) && !start. A beat is accepted when in_valid && in_ready.
- On each accept:
  - sig ← {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extend(f_vec).
  - vec_cnt+1.
  - ones_f1 / ones_f8 / mismatch_cnt each +1 when its condition holds.
- Counters saturate at all-ones and never wrap; only vec_cnt is bounded by NUM_VECTORS.
- Outside RUN, in_valid and f_vec are ignored. sig and the counters hold their values in DONE and IDLE.
- Reset mid-run discards the run: state←IDLE, sig←SEED, counters←0.

## Timing
- Reset values: in_ready=0, busy=0, done=0, sig=SEED, all counters 0.
- All outputs are registered except in_ready, which is combinational from state and start.
- A beat accepted at edge N is reflected in sig and the counters after edge N.
- done rises on the edge that accepts beat NUM_VECTORS. busy and in_ready fall on that same edge.
- start at edge N: busy=1 after N. The first acceptable beat is at edge N+1.
- start coincident with in_valid: no beat is accepted that cycle.
- Upstream must hold f_vec stable while in_valid && !in_ready. The block imposes no other back-pressure; in RUN it accepts one beat per cycle.
- done stays high until the next start or rst.

## Test plan
- Reset, then start. Feed 1 beat with f_vec=0x7FFFF (SEED=0, NUM_VECTORS=1) -> sig=0x0007FFFF, ones_f1=1, ones_f8=1, mismatch_cnt=0, done=1 one cycle after accept.
- NUM_VECTORS=2, two beats of f_vec=0x0687F (group A high, group B low) -> sig=0x0000B881, ones_f1=2, ones_f8=0, mismatch_cnt=0.
- Beat f_vec=0x0000F (f1..f4 high, rest of group A low) -> mismatch_cnt=1, ones_f1=1.
- Beats that set sig[31]=1 before the next accept -> that accept XORs in 0x04C11DB7; check against a bit-accurate model over 1024 random beats with random in_valid gaps.
- start pulsed mid-run with in_valid=1 -> in_ready=0 that cycle, counters=0 and sig=SEED the next cycle, vec_cnt restarts from 0.
- Async rst asserted between clock edges mid-run -> all outputs return to reset values immediately. in_valid=1 in IDLE is not accepted; vec_cnt stays 0 until start.

Source files
------------

// File: rtl/ccg_response_misr.sv
// Response compactor for CCGRCG219: folds each accepted 19-bit output vector into a MISR
// and keeps per-run ones/mismatch statistics for golden comparison.
module ccg_response_misr #(
  parameter int          SIG_W       = 32,
  parameter logic [31:0] POLY        = 32'h04C11DB7,
  parameter logic [31:0] SEED        = 32'h0,
  parameter int          NUM_VECTORS = 1024,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [18:0]      f_vec,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] ones_f1,
  output logic [CNT_W-1:0] ones_f8,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] vec_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [SIG_W-1:0] POLY_W = SIG_W'(POLY);
  localparam logic [SIG_W-1:0] SEED_W = SIG_W'(SEED);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(NUM_VECTORS - 1);
  // Copy groups: A replicates f1, B replicates f8.
  localparam logic [18:0]      GRP_A  = 19'h0687F;
  localparam logic [18:0]      GRP_B  = 19'h79780;

  state_t state;
  logic   accept, last, grp_a_ok, grp_b_ok, mismatch;
  logic [SIG_W-1:0] sig_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && c != '1) ? c + 1'b1 : c;
  endfunction

  assign in_ready = (state == RUN) && !start;
  assign accept   = in_valid && in_ready;
  assign last     = (vec_cnt == LAST);

  assign grp_a_ok = (&(f_vec | ~GRP_A)) || !(|(f_vec & GRP_A));
  assign grp_b_ok = (&(f_vec | ~GRP_B)) || !(|(f_vec & GRP_B));
  assign mismatch = !(grp_a_ok && grp_b_ok);

  assign sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY_W : '0) ^ SIG_W'(f_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      sig          <= SEED_W;
      ones_f1      <= '0;
      ones_f8      <= '0;
      mismatch_cnt <= '0;
      vec_cnt      <= '0;
    end else if (start) begin
      state        <= RUN;
      busy         <= 1'b1;
      done         <= 1'b0;
      sig          <= SEED_W;
      ones_f1      <= '0;
      ones_f8      <= '0;
      mismatch_cnt <= '0;
      vec_cnt      <= '0;
    end else if (accept) begin
      sig          <= sig_next;
      ones_f1      <= sat_inc(ones_f1, f_vec[0]);
      ones_f8      <= sat_inc(ones_f8, f_vec[7]);
      mismatch_cnt <= sat_inc(mismatch_cnt, mismatch);
      vec_cnt      <= vec_cnt + 1'b1;
      if (last) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ccg_response_misr.sv
// Randomized bench for ccg_response_misr: a spec-level model checked every cycle,
// plus literal expectations from worked examples.
module tb_ccg_response_misr;
  localparam int NV = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [18:0] f_vec = '0;

  logic        in_ready, busy, done;
  logic [31:0] sig;
  logic [15:0] ones_f1, ones_f8, mismatch_cnt, vec_cnt;

  logic        in_ready1, busy1, done1;
  logic [31:0] sig1;
  logic [15:0] ones_f1_1, ones_f8_1, mismatch_cnt1, vec_cnt1;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ccg_response_misr #(.NUM_VECTORS(NV)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .f_vec(f_vec), .sig(sig), .ones_f1(ones_f1), .ones_f8(ones_f8),
    .mismatch_cnt(mismatch_cnt), .vec_cnt(vec_cnt), .busy(busy), .done(done));

  ccg_response_misr #(.NUM_VECTORS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .f_vec(f_vec), .sig(sig1), .ones_f1(ones_f1_1), .ones_f8(ones_f8_1),
    .mismatch_cnt(mismatch_cnt1), .vec_cnt(vec_cnt1), .busy(busy1), .done(done1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state 0=idle 1=run 2=done
  int          m_state;
  logic [31:0] m_sig;
  int          m_ones1, m_ones8, m_mis, m_vec;

  function automatic bit group_bad(input logic [18:0] f);
    int na, nb;
    na = $countones(f & 19'h0687F);   // 10 copies of f1
    nb = $countones(f & 19'h79780);   // 9 copies of f8
    return !((na == 0 || na == 10) && (nb == 0 || nb == 9));
  endfunction

  function automatic logic [31:0] fold(input logic [31:0] s, input logic [18:0] f);
    logic [31:0] t;
    t = s << 1;
    if (s[31]) t = t ^ 32'h04C11DB7;
    return t ^ {13'd0, f};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0; m_sig <= '0; m_ones1 <= 0; m_ones8 <= 0; m_mis <= 0; m_vec <= 0;
    end else if (start) begin
      m_state <= 1; m_sig <= '0; m_ones1 <= 0; m_ones8 <= 0; m_mis <= 0; m_vec <= 0;
    end else if (m_state == 1 && in_valid) begin
      m_sig   <= fold(m_sig, f_vec);
      m_ones1 <= m_ones1 + int'(f_vec[0]);
      m_ones8 <= m_ones8 + int'(f_vec[7]);
      m_mis   <= m_mis + int'(group_bad(f_vec));
      m_vec   <= m_vec + 1;
      m_state <= (m_vec + 1 == NV) ? 2 : 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("sig", sig, m_sig);
      chk("ones_f1", ones_f1, m_ones1);
      chk("ones_f8", ones_f8, m_ones8);
      chk("mismatch_cnt", mismatch_cnt, m_mis);
      chk("vec_cnt", vec_cnt, m_vec);
      chk("busy", busy, m_state == 1);
      chk("done", done, m_state == 2);
      chk("in_ready", in_ready, m_state == 1 && !start);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  function automatic logic [18:0] rand_vec();
    logic [18:0] f;
    case ($urandom_range(0, 3))
      0, 1: f = 19'($urandom);
      2:    f = ($urandom_range(0, 1) ? 19'h0687F : 19'h0) | ($urandom_range(0, 1) ? 19'h79780 : 19'h0);
      default: f = 19'h7FFFF ^ (19'h1 << $urandom_range(0, 18));
    endcase
    return f;
  endfunction

  initial begin
    int n;
    #2 rst = 1'b1;
    cmp_en = 1'b1;
    cyc();
    cyc();
    chk("rst_sig", sig, 32'h0);
    chk("rst_vec", vec_cnt, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    rst = 1'b0;
    cyc();

    // One all-ones beat; the NUM_VECTORS=1 instance finishes on it.
    pulse_start();
    chk("busy_after_start", busy, 1'b1);
    in_valid = 1'b1; f_vec = 19'h7FFFF;
    cyc();
    in_valid = 1'b0;
    chk("ex1_sig", sig, 32'h0007FFFF);
    chk("ex1_ones_f1", ones_f1, 16'd1);
    chk("ex1_ones_f8", ones_f8, 16'd1);
    chk("ex1_mis", mismatch_cnt, 16'd0);
    chk("ex1_done_nv1", done1, 1'b1);
    chk("ex1_busy_nv1", busy1, 1'b0);
    chk("ex1_ready_nv1", in_ready1, 1'b0);
    chk("ex1_sig_nv1", sig1, 32'h0007FFFF);

    // Two back-to-back group-A-only beats.
    pulse_start();
    in_valid = 1'b1; f_vec = 19'h0687F;
    cyc();
    cyc();
    in_valid = 1'b0;
    chk("ex2_sig", sig, 32'h0000B881);
    chk("ex2_ones_f1", ones_f1, 16'd2);
    chk("ex2_ones_f8", ones_f8, 16'd0);
    chk("ex2_mis", mismatch_cnt, 16'd0);

    // Split group A.
    pulse_start();
    in_valid = 1'b1; f_vec = 19'h0000F;
    cyc();
    in_valid = 1'b0;
    chk("ex3_mis", mismatch_cnt, 16'd1);
    chk("ex3_ones_f1", ones_f1, 16'd1);
    chk("ex3_ones_f8", ones_f8, 16'd0);

    // Restart mid-run with a beat offered on the start cycle.
    in_valid = 1'b1; f_vec = 19'h12345;
    start = 1'b1;
    #1;
    chk("restart_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_vec", vec_cnt, 16'd0);
    chk("restart_sig", sig, 32'h0);
    cyc();
    chk("restart_vec1", vec_cnt, 16'd1);

    // Random run with gaps until the final beat.
    n = 0;
    while (!done && n < 8000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      f_vec    = rand_vec();
      cyc();
      n++;
    end
    in_valid = 1'b0;
    chk("rand_done_in_budget", done, 1'b1);
    chk("rand_vec_final", vec_cnt, 16'(NV));
    in_valid = 1'b1; f_vec = 19'h7FFFF;
    cyc();
    cyc();
    in_valid = 1'b0;
    chk("done_hold_vec", vec_cnt, 16'(NV));

    // Async reset between edges mid-run.
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; f_vec = rand_vec();
      cyc();
    end
    #3 rst = 1'b1;
    #1;
    chk("arst_sig", sig, 32'h0);
    chk("arst_vec", vec_cnt, 16'h0);
    chk("arst_ones_f1", ones_f1, 16'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ready", in_ready, 1'b0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; f_vec = rand_vec();
      cyc();
    end
    in_valid = 1'b0;
    chk("idle_vec", vec_cnt, 16'h0);
    chk("idle_done", done, 1'b0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
